chip8_mem_arbiter: RTL

- Shares the single-port 4096x8 program/font memory between requesters: CPU opcode fetch and the sprite/display engine.
- The memory has a synchronous read: the address is registered on the clk edge and data is valid the following cycle.
- The block accepts burst read requests (address + byte count), drives the memory address, and steers returned bytes to the granted requester.
- Sits between memory and its clients; it is the only driver of the memory address.

---
 rtl/chip8_mem_pkg.sv | 25 ++
 rtl/chip8_arb_pick.sv | 48 ++++
 rtl/chip8_mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/chip8_mem_pkg.sv
// Shared constants, FSM state encoding and burst-length decode for the CHIP-8 memory arbiter.
package chip8_mem_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W  = LEN_W + 1;

  localparam int unsigned REQ_CPU  = 0;
  localparam int unsigned REQ_DISP = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A zero length field encodes the maximum burst of 2^LEN_W bytes.
  function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] len);
    len_decode = (len == '0) ? CNT_W'(2 ** LEN_W) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/chip8_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// CHIP8_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority, lowest index wins.
module chip8_arb_pick
  import chip8_mem_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any_c,
  output logic [IDX_W-1:0] idx_c,
  output logic [NREQ-1:0]  gnt_c
);

`ifdef CHIP8_ARB_ROUND_ROBIN_EN
  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan starting one past the previous winner so every requester gets a turn.
  always_comb begin
    any_c = |req;
    idx_c = '0;
    gnt_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(last_grant) + 32'(k) + 32'd1) % 32'(NREQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx_c = cand;
      end
    end
    if (any_c) gnt_c[idx_c] = 1'b1;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    any_c = |req;
    idx_c = '0;
    gnt_c = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
    if (any_c) gnt_c[idx_c] = 1'b1;
  end
`endif

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Burst-read arbiter in front of the shared 4096x8 program/font memory (CPU fetch vs display).
// Arbitration policy is chosen by CHIP8_ARB_ROUND_ROBIN_EN inside chip8_arb_pick.
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_dout
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  chip8_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .any_c      (pick_any),
    .idx_c      (pick_idx),
    .gnt_c      (pick_gnt)
  );

  // Next-state logic. A byte's address is held in BURST for one cycle; the
  // memory returns it one cycle later, which is when rvalid/done are raised.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    mem_addr_d   = mem_addr_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    done_d       = '0;
    sel_addr     = '0;
    sel_len      = '0;

    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d        = pick_gnt;
          owner_d      = pick_idx;
          last_grant_d = pick_idx;
          mem_addr_d   = sel_addr;
          remaining_d  = len_decode(sel_len);
          state_d      = BURST;
        end
      end
      BURST: begin
        rvalid_d[owner_q] = 1'b1;
        remaining_d       = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          done_d[owner_q] = 1'b1;
          state_d         = DRAIN;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NREQ - 1);
      remaining_q  <= '0;
      mem_addr_q   <= '0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      mem_addr_q   <= mem_addr_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign rdata    = mem_dout;

endmodule
